// File: rtl/serial_compare_dispatcher.sv
// rtl/serial_compare_dispatcher.sv - operand FIFO and sequencer for the multi-bit serial comparator
// Queues (a, b) pairs, runs one comparison per pair and returns tagged flags over a valid/ready port.
module serial_compare_dispatcher #(
  parameter int n       = 3,
  parameter int DEPTH   = 4,
  parameter int CMP_LAT = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [n:0] in_a,
  input  logic [n:0] in_b,
  output logic       cmp_rst,
  output logic [n:0] cmp_a,
  output logic [n:0] cmp_b,
  input  logic       cmp_lt,
  input  logic       cmp_eq,
  input  logic       cmp_gt,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_lt,
  output logic       res_eq,
  output logic       res_gt,
  output logic       res_err,
  output logic [7:0] res_tag,
  output logic       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (CMP_LAT > 1) ? $clog2(CMP_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_HOLD} state_t;

  state_t        r_state;
  logic [n:0]    r_mem_a [DEPTH];
  logic [n:0]    r_mem_b [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_tag_cnt;
  logic [7:0]    r_pend_tag;

  logic w_push;
  logic w_pop;
  logic w_onehot;

  assign in_ready = (r_count < (AW+1)'(DEPTH));
  assign busy     = (r_state != S_IDLE);
  assign w_push   = in_valid && in_ready;
  assign w_pop    = (r_state == S_LOAD);
  assign w_onehot = ({cmp_lt, cmp_eq, cmp_gt} == 3'b100) ||
                    ({cmp_lt, cmp_eq, cmp_gt} == 3'b010) ||
                    ({cmp_lt, cmp_eq, cmp_gt} == 3'b001);

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr] <= in_a;
      r_mem_b[r_wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      cmp_rst    <= 1'b1;
      cmp_a      <= '0;
      cmp_b      <= '0;
      r_cnt      <= '0;
      r_tag_cnt  <= '0;
      r_pend_tag <= '0;
      res_valid  <= 1'b0;
      res_lt     <= 1'b0;
      res_eq     <= 1'b0;
      res_gt     <= 1'b0;
      res_err    <= 1'b0;
      res_tag    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          cmp_rst <= 1'b1;
          if (r_count != 0) r_state <= S_LOAD;
        end
        S_LOAD: begin
          cmp_a      <= r_mem_a[r_rd_ptr];
          cmp_b      <= r_mem_b[r_rd_ptr];
          r_pend_tag <= r_tag_cnt;
          r_tag_cnt  <= r_tag_cnt + 8'd1;
          r_cnt      <= CW'(CMP_LAT - 1);
          cmp_rst    <= 1'b0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == 0) begin
            {res_lt, res_eq, res_gt} <= {cmp_lt, cmp_eq, cmp_gt};
            res_err   <= !w_onehot;
            res_tag   <= r_pend_tag;
            res_valid <= 1'b1;
            cmp_rst   <= 1'b1;
            r_state   <= S_HOLD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_HOLD: begin
          cmp_rst <= 1'b1;
          if (res_ready) begin
            res_valid <= 1'b0;
            r_state   <= (r_count != 0) ? S_LOAD : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_compare_dispatcher.sv
// tb/tb_serial_compare_dispatcher.sv - self-checking bench for serial_compare_dispatcher
module tb_serial_compare_dispatcher;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       cmp_rst;
  logic [3:0] cmp_a;
  logic [3:0] cmp_b;
  logic       cmp_lt;
  logic       cmp_eq;
  logic       cmp_gt;
  logic       res_valid;
  logic       res_ready;
  logic       res_lt;
  logic       res_eq;
  logic       res_gt;
  logic       res_err;
  logic [7:0] res_tag;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int mode     = 0;
  int n_res    = 0;
  logic [7:0]  sb_tag = 8'd0;
  logic [7:0]  last_tag = 8'd0;
  logic [11:0] sb_q[$];

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    int         m;
    logic [3:0] exp;
  } vec_t;
  vec_t vecs[8];

  serial_compare_dispatcher #(.n(3), .DEPTH(4), .CMP_LAT(6)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .cmp_rst(cmp_rst), .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_lt(cmp_lt), .cmp_eq(cmp_eq), .cmp_gt(cmp_gt), .res_valid(res_valid),
    .res_ready(res_ready), .res_lt(res_lt), .res_eq(res_eq), .res_gt(res_gt),
    .res_err(res_err), .res_tag(res_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  // Comparator stand-in; modes 1 and 2 force malformed flag patterns.
  function automatic logic [3:0] model(input logic [3:0] a, input logic [3:0] b, input int m);
    if (m == 1) return 4'b0001;
    if (m == 2) return 4'b1011;
    return {a < b, a == b, a > b, 1'b0};
  endfunction

  logic [3:0] w_m;
  assign w_m = model(cmp_a, cmp_b, mode);
  assign cmp_lt = w_m[3];
  assign cmp_eq = w_m[2];
  assign cmp_gt = w_m[1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (in_valid && in_ready) begin
        sb_q.push_back({model(in_a, in_b, mode), sb_tag});
        sb_tag = sb_tag + 8'd1;
      end
      if (res_valid && res_ready) begin
        logic [11:0] e;
        n_res++;
        last_tag = res_tag;
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected actual=%0h required=none", {res_lt, res_eq, res_gt, res_err, res_tag});
        end else begin
          e = sb_q.pop_front();
          if ({res_lt, res_eq, res_gt, res_err, res_tag} !== e) begin
            failures++;
            $display("FAIL sb_result actual=%0h required=%0h", {res_lt, res_eq, res_gt, res_err, res_tag}, e);
          end
        end
      end
    end
  end

  task automatic push_pair(input logic [3:0] a, input logic [3:0] b);
    int t = 0;
    in_a = a; in_b = b; in_valid = 1'b1;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1; t++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (t >= 200) chk("push_timeout", 32'(t), 0);
  endtask

  task automatic wait_drain(input int bound);
    int t = 0;
    while ((sb_q.size() != 0 || busy) && t < bound) begin
      @(posedge clk); #1; t++;
    end
    if (t >= bound) chk("drain_timeout", 32'(sb_q.size()), 0);
  endtask

  task automatic wait_valid(input int bound);
    int t = 0;
    while (!res_valid && t < bound) begin
      @(posedge clk); #1; t++;
    end
    if (t >= bound) chk("valid_timeout", 32'(t), 0);
  endtask

  task automatic do_reset();
    #1 reset = 1'b0;
    sb_q.delete();
    sb_tag = 8'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    int k, low, acc, bad;
    logic last_rdy;
    logic [7:0] t0;
    vecs[0] = '{4'h3, 4'h9, 0, 4'b1000};
    vecs[1] = '{4'h9, 4'h3, 0, 4'b0010};
    vecs[2] = '{4'h7, 4'h7, 0, 4'b0100};
    vecs[3] = '{4'h0, 4'hF, 0, 4'b1000};
    vecs[4] = '{4'hF, 4'h0, 0, 4'b0010};
    vecs[5] = '{4'h0, 4'h0, 0, 4'b0100};
    vecs[6] = '{4'h5, 4'h6, 1, 4'b0001};
    vecs[7] = '{4'h5, 4'h6, 2, 4'b1011};

    reset = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", {in_ready, cmp_rst, res_valid, busy, cmp_a, cmp_b}, {4'b1100, 8'h00});
    chk("rst_result", {res_lt, res_eq, res_gt, res_err, res_tag}, 12'h000);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", {in_ready, cmp_rst, res_valid, busy}, 4'b1100);

    // Latency and compare window for a single pair.
    push_pair(4'h3, 4'h9);
    low = 0; k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (!cmp_rst) low++;
      if (res_valid) begin k = i; break; end
    end
    chk("latency", 32'(k), 8);
    chk("cmp_rst_low", 32'(low), 6);
    chk("first_result", {res_lt, res_eq, res_gt, res_err, res_tag}, {4'b1000, 8'd0});
    wait_drain(50);

    for (int i = 0; i < 8; i++) begin
      mode = vecs[i].m;
      push_pair(vecs[i].a, vecs[i].b);
      wait_valid(40);
      chk($sformatf("tbl_flags_%0d", i), {res_lt, res_eq, res_gt, res_err}, vecs[i].exp);
      wait_drain(50);
    end
    mode = 0;

    // Fill with result backpressure.
    do_reset();
    @(posedge clk); #1;
    res_ready = 1'b0; acc = 0; last_rdy = 1'b1; k = n_res;
    for (int i = 0; i < 6; i++) begin
      in_a = 4'(i); in_b = 4'(5 - i); in_valid = 1'b1;
      last_rdy = in_ready;
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("fill_accepted", 32'(acc), 5);
    chk("fill_sixth_refused", 32'(last_rdy), 0);
    res_ready = 1'b1;
    wait_drain(200);
    chk("fill_results", 32'(n_res - k), 5);
    chk("fill_last_tag", 32'(last_tag), 4);

    // Result held under backpressure, then redispatch after handshake.
    t0 = sb_tag;
    res_ready = 1'b0;
    push_pair(4'h5, 4'h5);
    push_pair(4'h2, 4'h1);
    wait_valid(40);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if ({res_valid, res_lt, res_eq, res_gt, res_err, res_tag, cmp_rst, cmp_a} !== {5'b10100, t0, 1'b1, 4'h5}) bad++;
      @(posedge clk); #1;
    end
    chk("hold_stable", 32'(bad), 0);
    res_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_release", {res_valid, cmp_rst, busy}, 3'b011);
    @(posedge clk); #1;
    chk("redispatch", {cmp_rst, cmp_a, cmp_b}, {1'b0, 4'h2, 4'h1});
    wait_drain(100);

    // Asynchronous reset while a comparison is in WAIT with pairs queued.
    push_pair(4'h1, 4'h2);
    push_pair(4'h3, 4'h4);
    push_pair(4'h5, 4'h6);
    @(posedge clk); #3;
    chk("pre_rst_wait", {busy, cmp_rst}, 2'b10);
    reset = 1'b0;
    #1;
    chk("async_rst", {cmp_rst, res_valid, in_ready, busy}, 4'b1010);
    sb_q.delete();
    sb_tag = 8'd0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    push_pair(4'hA, 4'hA);
    wait_valid(40);
    chk("tag_after_rst", {res_tag, res_eq}, {8'd0, 1'b1});
    wait_drain(50);

    // Tag wrap over 257 results.
    do_reset();
    @(posedge clk); #1;
    k = n_res;
    for (int i = 0; i < 257; i++) push_pair(4'(i), 4'(i * 7));
    wait_drain(400);
    chk("wrap_count", 32'(n_res - k), 257);
    chk("wrap_last_tag", 32'(last_tag), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_compare_dispatcher.md
Name: serial_compare_dispatcher

Overview:
- Operand-side controller for the multi-bit serial comparator stage.
- Buffers (a, b) operand pairs in a small FIFO and presents one pair at a time on the comparator's a_in/b_in.
- Pulses the comparator's active-high reset to start each comparison, waits a fixed compare window, then captures less_than/equal_to/greater_than.
- Returns the captured flags with a sequence tag over a valid/ready result port.

Parameters:
- n, 3, operand MSB index; operands are n+1 bits wide, matching the comparator.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CMP_LAT, 6, compare window in cycles between comparator-reset release and flag capture; minimum 1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  operand pair offered
- in_ready  output  1  FIFO can accept
- in_a  input  n+1  operand A
- in_b  input  n+1  operand B
- cmp_rst  output  1  drives the comparator reset (active-high)
- cmp_a  output  n+1  drives comparator a_in
- cmp_b  output  n+1  drives comparator b_in
- cmp_lt  input  1  comparator less_than
- cmp_eq  input  1  comparator equal_to
- cmp_gt  input  1  comparator greater_than
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- res_lt, res_eq, res_gt  output  1 each  captured flags
- res_err  output  1  captured flags were not one-hot
- res_tag  output  8  dispatch sequence number of this result
- busy  output  1  state != IDLE

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO empty; state IDLE; in_ready=1.
  - cmp_rst=1; cmp_a=cmp_b=0.
  - res_valid=0; res_lt/eq/gt/err=0; res_tag=0; internal tag counter=0; busy=0.
  - Any in-flight pair or pending result is discarded.
  - Reset release is synchronous to clk.
- Ingress:
  - Push occurs when in_valid && in_ready.
  - in_ready = (count < DEPTH), driven from registered count. When the FIFO is full, a push is refused even if a pop happens in the same cycle.
  - Pointers wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits.
- States: IDLE, LOAD, WAIT, HOLD.
  - IDLE: cmp_rst=1. If count != 0, go to LOAD next edge.
  - LOAD (1 cycle):
    - Pop the FIFO head into cmp_a/cmp_b; cmp_rst stays 1.
    - Tag counter is copied to a pending tag, then incremented (8-bit, 255 wraps to 0).
    - Go to WAIT.
  - WAIT:
    - cmp_rst=0; cmp_a/cmp_b held stable.
    - Down-counter is loaded with CMP_LAT-1 on entry and decrements each edge.
    - On the edge where the counter == 0, capture into result registers:
      - {res_lt, res_eq, res_gt} <= {cmp_lt, cmp_eq, cmp_gt}
      - res_err <= flags not exactly one-hot
      - res_tag <= pending tag
      - res_valid <= 1
      - go to HOLD.
  - HOLD:
    - cmp_rst=1 again; result registers stable while res_valid=1.
    - On res_ready: res_valid <= 0; go to LOAD if count != 0, otherwise IDLE.
    - res_ready is ignored outside HOLD, so res_valid is high for at least 1 cycle.
- Latency:
  - With the FIFO empty and the block idle, a pair accepted on edge E makes res_valid rise on edge E+CMP_LAT+2.
  - Defaults: 8 edges.
  - Back-to-back throughput with res_ready held high: one result per CMP_LAT+2 cycles.
- Push during LOAD, WAIT or HOLD is allowed while not full. A push and pop in the same cycle leave count unchanged.
- Result registers hold their last values after handshake until the next capture.

Test Plan:
- Single pair, n=3, CMP_LAT=6, comparator model returns lt=1,eq=0,gt=0:
  - push a=4'h3, b=4'h9 at edge E.
  - Expect cmp_rst low for exactly 6 cycles.
  - Expect res_valid at E+8 with res_lt=1, res_err=0, res_tag=0.
- Fill and backpressure:
  - res_ready=0; push 6 pairs back-to-back.
  - Expect the first 5 accepted (1 immediately popped into LOAD, 4 buffered), then in_ready=0.
  - Raise res_ready; all 5 results return in order with tags 0..4.
- Non-one-hot flags:
  - Model returns lt=0,eq=0,gt=0 → res_err=1, flags 000.
  - Model returns lt=1,eq=0,gt=1 → res_err=1.
- Result backpressure:
  - Hold res_ready=0 for 10 cycles after capture.
  - Expect res_valid and all result fields stable, cmp_rst=1, no new dispatch.
  - Dispatch begins 1 edge after the res_ready handshake.
- Reset mid-WAIT:
  - Assert reset=0 asynchronously between edges with 3 pairs queued.
  - Expect immediate cmp_rst=1, res_valid=0, in_ready=1, busy=0.
  - After release, a new pair returns res_tag=0.
- Tag wrap:
  - Push 257 pairs.
  - Expect res_tag sequence ...254, 255, 0 for the final results, with no dropped or duplicated results.
